// File: rtl/cla_seq_if.sv
// Handshake and operand/result bundle for cla_seq_ctrl.
// Optional subtract input is present only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef CLA_SEQ_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   // Producer/consumer side (testbench or upstream logic)
   modport master (
`ifdef CLA_SEQ_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   // Adder side
   modport slave (
`ifdef CLA_SEQ_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Sequential adder: one 4-bit carry-lookahead slice reused over WIDTH/4
// nibbles, LSB first, behind a valid/ready handshake on both sides.
// Optional feature macro: CLA_SEQ_SUB_EN adds the 'sub' input (a - b).
module cla_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst,
   cla_seq_if.slave bus
);
   localparam int unsigned N    = WIDTH / 4;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // already inverted when subtracting
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [IDXW+1:0]  base_c;
   logic [3:0]       nib_a_c;
   logic [3:0]       nib_b_c;
   logic [3:0]       nib_g_c;
   logic [3:0]       nib_p_c;
   logic [4:0]       nib_c_c;
   logic [3:0]       nib_sum_c;
   logic             ovf_c;
   logic [WIDTH-1:0] b_in_c;
   logic             cin_in_c;

   // Operand conditioning at accept: invert b and force carry for subtract
   always_comb begin
      b_in_c   = bus.b;
      cin_in_c = bus.cin;
`ifdef CLA_SEQ_SUB_EN
      if (bus.sub) begin
         b_in_c   = ~bus.b;
         cin_in_c = 1'b1;
      end
`endif
   end

   // The single 4-bit carry-lookahead slice on the current nibble
   always_comb begin
      base_c    = {idx_q, 2'b00};
      nib_a_c   = a_q[base_c +: 4];
      nib_b_c   = b_q[base_c +: 4];
      nib_g_c   = nib_a_c & nib_b_c;
      nib_p_c   = nib_a_c ^ nib_b_c;
      nib_c_c[0] = carry_q;
      nib_c_c[1] = nib_g_c[0] | (nib_p_c[0] & carry_q);
      nib_c_c[2] = nib_g_c[1] | (nib_p_c[1] & nib_g_c[0])
                 | (nib_p_c[1] & nib_p_c[0] & carry_q);
      nib_c_c[3] = nib_g_c[2] | (nib_p_c[2] & nib_g_c[1])
                 | (nib_p_c[2] & nib_p_c[1] & nib_g_c[0])
                 | (nib_p_c[2] & nib_p_c[1] & nib_p_c[0] & carry_q);
      nib_c_c[4] = nib_g_c[3] | (nib_p_c[3] & nib_g_c[2])
                 | (nib_p_c[3] & nib_p_c[2] & nib_g_c[1])
                 | (nib_p_c[3] & nib_p_c[2] & nib_p_c[1] & nib_g_c[0])
                 | (nib_p_c[3] & nib_p_c[2] & nib_p_c[1] & nib_p_c[0] & carry_q);
      nib_sum_c = nib_p_c ^ nib_c_c[3:0];
      // Only meaningful on the MSB nibble, where nib_sum_c[3] is the sum MSB
      ovf_c     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum_c[3] != a_q[WIDTH-1]);
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.a;
                  b_q        <= b_in_c;
                  carry_q    <= cin_in_c;
                  idx_q      <= '0;
                  sum_q      <= '0;
                  cout_q     <= 1'b0;
                  ovf_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q[base_c +: 4] <= nib_sum_c;
               carry_q            <= nib_c_c[4];
               idx_q              <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(N - 1)) begin
                  idx_q       <= '0;
                  cout_q      <= nib_c_c[4];
                  ovf_q       <= ovf_c;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = busy_q;
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits; a multiple of 4 and at least 8; N = WIDTH/4 nibble steps.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in of the whole operation.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-011 The block SHALL have port cout, output, 1 bit: the carry out of the MSB nibble.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow of the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-014 The block SHALL contain exactly one 4-bit carry-lookahead adder slice, time-shared over the N nibbles, LSB nibble first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On an IDLE edge with in_valid=1, the block SHALL register a, b and cin into internal operand registers, clear the nibble index and enter RUN.
REQ-017 On each RUN edge, the slice SHALL add nibble[idx] of the registered a and b plus the carry register; the block SHALL write the sum into sum[4*idx+3:4*idx], load the slice carry-out into the carry register and increment idx.
REQ-018 After the edge that processes idx = N-1, the block SHALL enter DONE; out_valid SHALL therefore rise exactly N edges after the accepting edge (4 for WIDTH=16).
REQ-019 In DONE, cout SHALL equal the final carry, and ovf SHALL equal (a_msb == beff_msb) && (sum_msb != a_msb), where beff is b, or ~b when subtracting.
REQ-020 While out_valid=1, the values of sum, cout and ovf SHALL be held stable, and out_valid SHALL NOT drop until the handshake completes.
REQ-021 On a DONE edge with out_ready=1, the block SHALL return to IDLE; it SHALL NOT skip IDLE, so the minimum initiation interval is N+2 cycles.
REQ-022 The block SHALL ignore in_valid outside IDLE and SHALL ignore out_ready outside DONE; operand inputs SHALL NOT be sampled after the accepting edge.
REQ-023 sum SHALL be zero-extended-free and modulo 2^WIDTH; wrap-around SHALL be reported only through cout and ovf.

Reset
REQ-024 While rst=1, the block SHALL immediately force state=IDLE, idx=0, carry=0, the operand registers to 0, sum=0, cout=0, ovf=0, out_valid=0, busy=0 and in_ready=1.
REQ-025 A reset asserted during RUN or DONE SHALL abort the operation and discard its result; the first in_valid after reset release SHALL start a fresh operation.

Configuration
REQ-026 When macro CLA_SEQ_SUB_EN is defined, the block SHALL add input port sub (1 bit, registered at accept); when sub=1 it SHALL feed ~b to the slice and force the initial carry to 1, ignoring cin, and cout=1 SHALL mean no borrow.
REQ-027 When CLA_SEQ_SUB_EN is undefined, port sub SHALL be absent and the block SHALL only add.

Verification
REQ-028 The bench SHALL apply a=0xFFFF, b=0x0001, cin=0 and check that out_valid rises 4 edges after accept with sum=0x0000, cout=1, ovf=0.
REQ-029 The bench SHALL apply a=0x1234, b=0x4321, cin=1 and check sum=0x5556, cout=0, ovf=0; then apply a=0x7FFF, b=0x0001 and check sum=0x8000, ovf=1.
REQ-030 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that out_valid, sum and cout stay constant; after out_ready=1, IDLE and in_ready=1 SHALL follow on the next edge.
REQ-031 The bench SHALL toggle in_valid and change a and b during RUN and check that the result matches the originally accepted operands and that in_ready stays 0.
REQ-032 The bench SHALL assert rst for 1 cycle after 2 RUN edges and check that all outputs go to their reset values immediately, with no out_valid, and that the next operation completes correctly.
REQ-033 With CLA_SEQ_SUB_EN defined, the bench SHALL apply sub=1, a=0x0005, b=0x0007 and check sum=0xFFFE, cout=0; then apply a=0x0007, b=0x0005 and check sum=0x0002, cout=1.
